// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor. Computes a - b one bit per clock,
// LSB first, with a single full-subtractor cell and a registered borrow.
// Each operation runs IDLE -> RUN (WIDTH edges) -> DONE. Operands come in and
// the result goes out through valid/ready handshakes. Operations do not
// overlap.
//
// Optional feature: define SERIAL_SUB_OVERFLOW_EN to add the 'overflow'
// output. It flags signed two's-complement overflow of the result.
//
// Parameters:
//   WIDTH        operand/result width in bits (1..64)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start_valid  operands a/b valid
//   start_ready  block can accept operands (high only in IDLE)
//   a            minuend, sampled on the start handshake
//   b            subtrahend, sampled on the start handshake
//   done_valid   diff/borrow_out valid (high only in DONE)
//   done_ready   consumer accepts the result
//   diff         a - b modulo 2^WIDTH
//   borrow_out   final borrow; 1 iff unsigned a < b
//   overflow     (SERIAL_SUB_OVERFLOW_EN only) signed overflow flag
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow_out;

  logic             w_bit;
  logic             w_borrow_nxt;
  logic [WIDTH-1:0] w_diff_nxt;
  logic             w_last;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_overflow;
`endif

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  assign w_bit        = r_a[0] ^ r_b[0] ^ r_borrow;
  assign w_borrow_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);
  assign w_last       = (r_cnt == LAST_CNT);

  // The new bit enters at the MSB, so after WIDTH shifts the first bit
  // computed (bit 0) has reached the LSB. A one-bit result is just the bit.
  generate
    if (WIDTH == 1) begin : g_diff_w1
      assign w_diff_nxt = w_bit;
    end else begin : g_diff_wn
      assign w_diff_nxt = {w_bit, r_diff[WIDTH-1:1]};
    end
  endgenerate

  // NOTE: every register here is state updated on the clock edge, so all
  // assignments are non-blocking; blocking ones would let later statements
  // see the new values of earlier ones within the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_diff       <= '0;
      r_borrow     <= 1'b0;
      r_cnt        <= '0;
      r_borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      r_a_msb      <= 1'b0;
      r_b_msb      <= 1'b0;
      r_overflow   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_state  <= ST_RUN;
`ifdef SERIAL_SUB_OVERFLOW_EN
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
`endif
          end
        end

        ST_RUN: begin
          r_diff   <= w_diff_nxt;
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_borrow <= w_borrow_nxt;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_state      <= ST_DONE;
            r_borrow_out <= w_borrow_nxt;
`ifdef SERIAL_SUB_OVERFLOW_EN
            // The result MSB on this edge is the bit being computed now.
            r_overflow   <= (r_a_msb != r_b_msb) && (w_bit != r_a_msb);
`endif
          end
        end

        ST_DONE: begin
          if (done_ready) begin
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign start_ready = (r_state == ST_IDLE);
  assign done_valid  = (r_state == ST_DONE);
  assign diff        = r_diff;
  assign borrow_out  = r_borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign overflow    = r_overflow;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed bench for serial_subtractor. An 8-bit instance runs the
// arithmetic, back-pressure and reset cases. A 1-bit instance runs
// back-to-back operations. Outputs are sampled 1 time unit after the rising
// edge. Inputs are driven from the single initial block.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;

  logic       sv8, sr8, dv8, dr8, bo8, ov8;
  logic [7:0] a8, b8, d8;

  logic       sv1, sr1, dv1, dr1, bo1, ov1;
  logic [0:0] a1, b1, d1;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(sv8), .start_ready(sr8), .a(a8), .b(b8),
    .done_valid(dv8), .done_ready(dr8), .diff(d8), .borrow_out(bo8)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .overflow(ov8)
`endif
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(sv1), .start_ready(sr1), .a(a1), .b(b1),
    .done_valid(dv1), .done_ready(dr1), .diff(d1), .borrow_out(bo1)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .overflow(ov1)
`endif
  );

`ifndef SERIAL_SUB_OVERFLOW_EN
  assign ov8 = 1'b0;
  assign ov1 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one 8-bit operation, check the exact WIDTH-edge latency, then the
  // result. The result handshake is left to the caller via dr8.
  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] ed, input logic eb, input logic eo);
    a8  = av;
    b8  = bv;
    sv8 = 1'b1;
    check({tag, ".start_ready"}, 64'(sr8), 64'd1);
    tick();                       // accept edge
    sv8 = 1'b0;
    check({tag, ".in_run"}, 64'(sr8), 64'd0);
    repeat (7) tick();
    check({tag, ".not_yet_done"}, 64'(dv8), 64'd0);
    tick();                       // 8th RUN edge
    check({tag, ".done_valid"}, 64'(dv8), 64'd1);
    check({tag, ".diff"}, 64'(d8), 64'(ed));
    check({tag, ".borrow"}, 64'(bo8), 64'(eb));
`ifdef SERIAL_SUB_OVERFLOW_EN
    check({tag, ".overflow"}, 64'(ov8), 64'(eo));
`else
    if (eo !== eo) $display("unused");
`endif
  endtask

  logic [0:0] t_a [3] = '{1'b1, 1'b0, 1'b1};
  logic [0:0] t_b [3] = '{1'b0, 1'b1, 1'b1};
  logic [0:0] t_d [3] = '{1'b1, 1'b1, 1'b0};
  logic       t_o [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0;
    sv8 = 1'b0; dr8 = 1'b1; a8 = '0; b8 = '0;
    sv1 = 1'b0; dr1 = 1'b1; a1 = '0; b1 = '0;
    #1;
    check("rst.start_ready", 64'(sr8), 64'd1);
    check("rst.done_valid", 64'(dv8), 64'd0);
    check("rst.diff", 64'(d8), 64'd0);
    check("rst.borrow", 64'(bo8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic subtract, consumer always ready.
    op8("basic", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
    tick();
    check("basic.back_idle", 64'(sr8), 64'd1);

    // Back-pressure: result held while a new start is presented and ignored.
    dr8 = 1'b0;
    op8("bp", 8'h33, 8'h11, 8'h22, 1'b0, 1'b0);
    a8 = 8'hFF; b8 = 8'h00; sv8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.hold_valid", 64'(dv8), 64'd1);
      check("bp.hold_diff", 64'(d8), 64'h22);
      check("bp.hold_ready", 64'(sr8), 64'd0);
    end
    dr8 = 1'b1;
    tick();                       // result handshake edge
    check("bp.released", 64'(dv8), 64'd0);
    check("bp.idle", 64'(sr8), 64'd1);
    op8("bp_next", 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);
    tick();

    // Signed overflow and unsigned underflow wrap.
    op8("ovf", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    tick();
    op8("wrap", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    tick();

    // Reset three edges into RUN; the outputs must clear with no clock edge.
    a8 = 8'h5A; b8 = 8'h3C; sv8 = 1'b1;
    tick();
    sv8 = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst.start_ready", 64'(sr8), 64'd1);
    check("mid_rst.done_valid", 64'(dv8), 64'd0);
    check("mid_rst.diff", 64'(d8), 64'd0);
    check("mid_rst.borrow", 64'(bo8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mid_rst.no_pulse", 64'(dv8), 64'd0);
    op8("post_rst", 8'h10, 8'h10, 8'h00, 1'b0, 1'b0);
    tick();

    // WIDTH=1 back-to-back with start_valid and done_ready held high.
    dr1 = 1'b1;
    sv1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a1 = t_a[k];
      b1 = t_b[k];
      check("w1.ready", 64'(sr1), 64'd1);
      tick();                     // accept
      check("w1.run", 64'(dv1), 64'd0);
      tick();                     // single RUN edge
      check("w1.done_valid", 64'(dv1), 64'd1);
      check("w1.diff", 64'(d1), 64'(t_d[k]));
      check("w1.borrow", 64'(bo1), 64'(t_o[k]));
      tick();                     // result handshake
      check("w1.dropped", 64'(dv1), 64'd0);
    end
    sv1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
